// File: rtl/yutorina_id_hazard_unit_pkg.sv
// yutorina_id_hazard_unit_pkg: shared constants for the decode-stage hazard unit
package yutorina_id_hazard_unit_pkg;
  localparam int GPR_ZERO = 0;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  // Loads become forwardable after the memory stage, two non-stalled cycles after issue
  localparam int MEM_LD_LAT = 2;
endpackage

// File: rtl/yutorina_fwd_mux.sv
// yutorina_fwd_mux: per-port priority forward selector, lowest tap index wins
module yutorina_fwd_mux
  import yutorina_id_hazard_unit_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [ADDR_W-1:0]         rd_addr,
  input  logic [DATA_W-1:0]         gpr_data,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD-1:0]        fwd_we_,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]         rd_data
);
  always_comb begin
    rd_data = gpr_data;
    for (int j = NUM_FWD - 1; j >= 0; j--)
      if (!fwd_we_[j] && fwd_addr[j*ADDR_W +: ADDR_W] == rd_addr && rd_addr != ADDR_W'(GPR_ZERO))
        rd_data = fwd_data[j*DATA_W +: DATA_W];
  end
endmodule

// File: rtl/yutorina_id_hazard_unit.sv
// yutorina_id_hazard_unit: operand forwarding and load-latency scoreboard for decode
module yutorina_id_hazard_unit
  import yutorina_id_hazard_unit_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_RD = 2,
  parameter int NUM_FWD = 2,
  parameter int LD_LAT = MEM_LD_LAT,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      issue_en_,
  input  logic                      issue_gpr_we_,
  input  logic                      issue_is_ld,
  input  logic [ADDR_W-1:0]         issue_w_addr,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  input  logic [NUM_RD-1:0]         rd_used,
  input  logic [NUM_RD*DATA_W-1:0]  rd_gpr_data,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD-1:0]        fwd_we_,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [NUM_RD*DATA_W-1:0]  rd_data,
  output logic                      ld_haz,
  output logic [(1<<ADDR_W)-1:0]    busy_vec,
  output logic [CNT_W-1:0]          haz_cycles
);
  localparam int NREG = 1 << ADDR_W;
  localparam int CW = $clog2(LD_LAT + 1);
  logic [CW-1:0] cnt [NREG];
  logic [CW-1:0] cnt_nxt [NREG];
  logic [NUM_RD-1:0] haz;
  logic issue_ok, wr_hit;
  for (genvar r = 0; r < NREG; r++) begin : g_busy
    assign busy_vec[r] = cnt[r] != '0;
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
    assign haz[i] = rd_used[i] && a != ADDR_W'(GPR_ZERO) && busy_vec[a];
    yutorina_fwd_mux #(.NUM_FWD(NUM_FWD), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd_mux (
      .rd_addr  (a),
      .gpr_data (rd_gpr_data[i*DATA_W +: DATA_W]),
      .fwd_addr (fwd_addr),
      .fwd_we_  (fwd_we_),
      .fwd_data (fwd_data),
      .rd_data  (rd_data[i*DATA_W +: DATA_W])
    );
  end
  assign ld_haz = |haz;
  assign issue_ok = !issue_en_ && !stall && !flush && !ld_haz;
  assign wr_hit = issue_ok && !issue_gpr_we_ && issue_w_addr != ADDR_W'(GPR_ZERO);
  // A new writer overrides the decrement: loads rearm the countdown, other writes retire it (WAW)
  always_comb begin
    for (int r = 0; r < NREG; r++)
      cnt_nxt[r] = cnt[r] != '0 ? cnt[r] - CW'(1) : '0;
    if (wr_hit) cnt_nxt[issue_w_addr] = issue_is_ld ? CW'(LD_LAT) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      haz_cycles <= '0;
    end else begin
      if (ld_haz && haz_cycles != '1) haz_cycles <= haz_cycles + CNT_W'(1);
      for (int r = 0; r < NREG; r++)
        cnt[r] <= flush ? '0 : stall ? cnt[r] : cnt_nxt[r];
    end
  end
endmodule

// File: doc/yutorina_id_hazard_unit.md
Name: yutorina_id_hazard_unit

Overview:
Parametrised operand-forwarding and load-hazard scoreboard for the decode stage. It generalises single-pair forwarding and single-cycle load detection to NUM_RD read ports, NUM_FWD prioritised forward sources and an arbitrary load latency LD_LAT. A per-GPR countdown scoreboard tracks in-flight loads. The block sits between the GPR file, the downstream forward taps and the instruction decoder. It drives the decode-stage stall (ld_haz) and keeps a saturating hazard-cycle counter for performance monitoring.

Parameters:
ADDR_W, 5, GPR address width; the block tracks 2**ADDR_W registers.
DATA_W, 32, data word width.
NUM_RD, 2, number of operand read ports.
NUM_FWD, 2, number of forward sources; index 0 is the youngest (EX) and has the highest priority.
LD_LAT, 2, number of non-stalled cycles from load issue until its data is valid on a forward tap; must be >= 1.
CNT_W, 16, width of the hazard-cycle counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
stall  in  1  global pipeline stall; freezes the scoreboard
flush  in  1  pipeline flush; clears the scoreboard
issue_en_  in  1  active-low: the decoder presents a valid instruction
issue_gpr_we_  in  1  active-low: the instruction writes a GPR
issue_is_ld  in  1  the instruction is a load (any width or signedness)
issue_w_addr  in  ADDR_W  destination GPR
rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at slice i
rd_used  in  NUM_RD  port i operand is actually consumed
rd_gpr_data  in  NUM_RD*DATA_W  raw GPR file data
fwd_addr  in  NUM_FWD*ADDR_W  forward tap destination addresses
fwd_we_  in  NUM_FWD  active-low forward tap valid
fwd_data  in  NUM_FWD*DATA_W  forward tap data
rd_data  out  NUM_RD*DATA_W  resolved operands (combinational)
ld_haz  out  1  decode must stall (combinational)
busy_vec  out  2**ADDR_W  registered: bit r set while GPR r has a pending load
haz_cycles  out  CNT_W  saturating count of cycles with ld_haz=1

Behaviour:
- Clock and reset: one clock, clk. Synchronous active-high reset, rst.
- Reset state: all scoreboard counters 0, busy_vec=0, haz_cycles=0. Reset mid-operation discards every pending load on the next edge.
- Scoreboard storage: one down-counter per GPR, width clog2(LD_LAT+1). busy_vec[r] = (cnt[r]!=0).
- GPR 0: never busy. Its operand is always rd_gpr_data and is never forwarded.
- Per-port hazard: haz_i = rd_used[i] & (rd_addr_i!=0) & (cnt[rd_addr_i]!=0).
- Stall output: ld_haz = OR of haz_i across all ports.
- Issue acceptance: issue_ok = !issue_en_ & !stall & !flush & !ld_haz.
- Edge update, in priority order (highest first):
  1. rst: clear all counters and haz_cycles.
  2. flush: clear all counters; haz_cycles still updates.
  3. stall: all counters hold.
  4. Otherwise: every nonzero counter decrements by 1. Then, if issue_ok & !issue_gpr_we_ & issue_is_ld & issue_w_addr!=0, cnt[issue_w_addr] := LD_LAT. The issue write wins over a decrement of the same register.
- Non-load write to a busy register: if issue_ok with issue_is_ld=0 targets a busy register, that register is cleared to 0. The younger writer supersedes the pending load (WAW).
- Forwarding, per port i: choose the lowest index j with !fwd_we_[j] & fwd_addr_j==rd_addr_i & rd_addr_i!=0 and output fwd_data_j. If no tap matches, output rd_gpr_data_i.
- Stalled cycles: forward resolution stays purely combinational and is still evaluated while ld_haz=1.
- haz_cycles: increments on each edge where ld_haz=1 and rst=0. It saturates at all-ones and does not wrap.
- Latency: a load issued at edge k makes ld_haz assert for dependent readers during cycles k+1 .. k+LD_LAT, with no stalls in between. At cycle k+LD_LAT+1 the operand resolves through the forward taps.

Decomposition:
- Shared package (header include): GPR_ZERO, the default ADDR_W/DATA_W, and the LD_LAT constant tied to the memory-stage depth.
- Natural sub-module: yutorina_fwd_mux. It is the per-port priority forward selector, parametrised by NUM_FWD/ADDR_W/DATA_W and instantiated NUM_RD times via generate. The scoreboard and counters stay in the top module.

Test Plan:
- Load-use stall (LD_LAT=2): issue load to r5 at edge 0; read r5 on port 0 with rd_used=1 -> ld_haz=1 in cycles 1 and 2, 0 in cycle 3; haz_cycles=2.
- Forward priority: fwd0=(r3,0xAAAA0000,valid), fwd1=(r3,0x5555,valid), gpr=0x1 -> rd_data port0=0xAAAA0000. With fwd0 invalid -> 0x5555. Reading r0 -> gpr data 0x0.
- Stall freeze: load r7 at edge 0; stall=1 for 3 cycles; busy_vec[7] stays 1 throughout; ld_haz clears exactly 2 non-stalled cycles after stall deasserts.
- Flush and WAW:
  - Pending load r9, flush=1 for one edge -> busy_vec=0 and ld_haz=0 next cycle.
  - Separately: pending load r9, an ALU write to r9 issued -> busy_vec[9]=0.
- Unused operand and r0: load r4 pending; read r4 with rd_used=0 -> ld_haz=0. A load issued to r0 -> busy_vec stays 0.
- Saturation and reset: CNT_W=4, hold a hazard for 20 cycles -> haz_cycles=15. Assert rst mid-load -> all outputs 0 on the next edge.
